// File: rtl/ata_pio_ctrl.sv
// ATA PIO cycle controller for the Gayle-style IDE window: decodes CPU cycles into
// chip selects and timed IOR/IOW strobes, honours IORDY with a timeout, returns DTACK.
module ata_pio_ctrl #(
    parameter int unsigned NUM_PORTS      = 1,
    parameter logic [8:0]  BASE           = 9'h1B4,
    parameter int unsigned T_SETUP        = 1,
    parameter int unsigned T_ACTIVE       = 3,
    parameter int unsigned T_RECOVER      = 2,
    // IORDY wait limit; named so it does not collide with the TIMEOUT output port
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter bit          IORDY_EN       = 1'b1
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     AS,
    input  logic                     RW,
    input  logic [23:0]              A,
    input  logic                     IORDY,
    output logic [2*NUM_PORTS-1:0]   IDECS,
    output logic                     IOR,
    output logic                     IOW,
    output logic                     DTACK,
    output logic                     ACCESS,
    output logic                     TIMEOUT
);

    localparam int unsigned CS_W  = 2 * NUM_PORTS;
    localparam int unsigned MAX_SA = (T_SETUP > T_ACTIVE) ? T_SETUP : T_ACTIVE;
    localparam int unsigned MAX_RT = (T_RECOVER > TIMEOUT_CYCLES) ? T_RECOVER : TIMEOUT_CYCLES;
    localparam int unsigned MAX_T  = (MAX_SA > MAX_RT) ? MAX_SA : MAX_RT;
    localparam int unsigned CNT_W  = $clog2(MAX_T + 1);

    localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] ACTIVE_LOAD = CNT_W'(T_ACTIVE - 1);
    localparam logic [CNT_W-1:0] WAIT_LOAD   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] REC_LOAD    = (T_RECOVER == 0) ? CNT_W'(0) : CNT_W'(T_RECOVER - 1);

    generate
        if (NUM_PORTS < 1 || NUM_PORTS > 2) begin : g_bad_ports
            $error("ata_pio_ctrl: NUM_PORTS must be 1 or 2");
        end
        if (T_SETUP < 1 || T_ACTIVE < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_timing
            $error("ata_pio_ctrl: T_SETUP, T_ACTIVE and TIMEOUT_CYCLES must be at least 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_ACTIVE  = 3'd2,
        S_WAIT    = 3'd3,
        S_ACK     = 3'd4,
        S_RECOVER = 3'd5
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              as_s_q, as_s_d;
    logic              port_q, port_d;
    logic              cs_q, cs_d;
    logic              rw_q, rw_d;
    logic [CS_W-1:0]   idecs_q, idecs_d;
    logic              ior_q, ior_d;
    logic              iow_q, iow_d;
    logic              dtack_q, dtack_d;
    logic              timeout_q, timeout_d;

    logic              addr_match;
    logic              hit;
    state_e            end_state;
    logic [3:0]        cs_onehot;
    logic              unused_a;

    assign addr_match = (A[23:15] == BASE);
    assign hit        = !as_s_q && addr_match;
    assign end_state  = (T_RECOVER == 0) ? S_IDLE : S_RECOVER;
    assign unused_a   = ^{A[14:13], A[11:0]};

    // Next-state, counter and latched-cycle attributes
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        port_d    = port_q;
        cs_d      = cs_q;
        rw_d      = rw_q;
        timeout_d = 1'b0;
        as_s_d    = AS;

        case (state_q)
            S_IDLE: begin
                if (hit) begin
                    state_d = S_SETUP;
                    cnt_d   = SETUP_LOAD;
                    port_d  = (NUM_PORTS == 2) ? A[13] : 1'b0;
                    cs_d    = A[12];
                    rw_d    = RW;
                end
            end
            S_SETUP: begin
                if (as_s_q) begin
                    state_d = end_state;
                    cnt_d   = REC_LOAD;
                end else if (cnt_q == '0) begin
                    state_d = S_ACTIVE;
                    cnt_d   = ACTIVE_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_ACTIVE: begin
                if (as_s_q) begin
                    state_d = end_state;
                    cnt_d   = REC_LOAD;
                end else if (cnt_q == '0) begin
                    if (IORDY_EN && !IORDY) begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end else begin
                        state_d = S_ACK;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_WAIT: begin
                // Ready takes priority over an expiring timeout on the same edge
                if (as_s_q) begin
                    state_d = end_state;
                    cnt_d   = REC_LOAD;
                end else if (IORDY) begin
                    state_d = S_ACK;
                end else if (cnt_q == '0) begin
                    state_d   = S_ACK;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_ACK: begin
                if (as_s_q) begin
                    state_d = end_state;
                    cnt_d   = REC_LOAD;
                end
            end
            S_RECOVER: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Bus outputs decoded from the current state, registered one edge later
    always_comb begin
        idecs_d   = '1;
        ior_d     = 1'b1;
        iow_d     = 1'b1;
        dtack_d   = 1'b1;
        cs_onehot = 4'b0001 << {port_q, cs_q};

        case (state_q)
            S_SETUP: begin
                idecs_d = ~cs_onehot[CS_W-1:0];
            end
            S_ACTIVE, S_WAIT: begin
                idecs_d = ~cs_onehot[CS_W-1:0];
                ior_d   = !rw_q;
                iow_d   = rw_q;
            end
            S_ACK: begin
                // IOW already released so write data outlives the strobe by one cycle
                idecs_d = ~cs_onehot[CS_W-1:0];
                ior_d   = !rw_q;
                dtack_d = 1'b0;
            end
            default: begin
                idecs_d = '1;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            as_s_q    <= 1'b1;
            port_q    <= 1'b0;
            cs_q      <= 1'b0;
            rw_q      <= 1'b0;
            idecs_q   <= '1;
            ior_q     <= 1'b1;
            iow_q     <= 1'b1;
            dtack_q   <= 1'b1;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            as_s_q    <= as_s_d;
            port_q    <= port_d;
            cs_q      <= cs_d;
            rw_q      <= rw_d;
            idecs_q   <= idecs_d;
            ior_q     <= ior_d;
            iow_q     <= iow_d;
            dtack_q   <= dtack_d;
            timeout_q <= timeout_d;
        end
    end

    assign IDECS   = idecs_q;
    assign IOR     = ior_q;
    assign IOW     = iow_q;
    assign DTACK   = dtack_q;
    assign TIMEOUT = timeout_q;
    assign ACCESS  = !addr_match;

endmodule
